c157x_mem_arb: RTL

C157X_MEM_ARB -- requirements
Module: c157x_mem_arb

---
 rtl/iecdrv_pkg.sv | 23 ++
 rtl/c157x_mem_arb.sv | 125 ++++++++++++
 2 files changed

// File: rtl/iecdrv_pkg.sv
// Shared types for the IEC drive memory subsystem.
// Holds the host/CPU arbiter state encoding and small helpers used by the
// arbiter that sits in front of the drive RAM.
package iecdrv_pkg;

    // Host access sequencing in the memory arbiter
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_t;

    // Value host_dout shows before any host read has completed
    localparam logic [7:0] HOST_DOUT_RESET = 8'hFF;

    // A CPU write commits on the phase-rise strobe when the CPU selects the RAM
    function automatic logic cpu_write_strobe(input logic ena_r,
                                              input logic sel,
                                              input logic we);
        return ena_r & sel & we;
    endfunction

endpackage

// File: rtl/c157x_mem_arb.sv
// Drive RAM arbiter between the drive CPU and a host port.
// The CPU owns the RAM except for a short window after each phase-fall
// strobe; host accesses are squeezed into that window as a two-clk
// ADDR/DATA sequence. CPU writes always win the RAM port for their clk.
module c157x_mem_arb
    import iecdrv_pkg::*;
#(
    parameter int AW  = 11,
    parameter int WIN = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_ena_f,
    input  logic          cpu_ena_r,
    input  logic          cpu_sel,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [7:0]    host_din,
    output logic          host_ack,
    output logic [7:0]    host_dout,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_din,
    output logic          mem_we,
    input  logic [7:0]    mem_q,
    output logic          busy
);

    localparam int CW = (WIN < 1) ? 1 : $clog2(WIN + 1);
    localparam logic [CW-1:0] WIN_LOAD = CW'(WIN);

    arb_state_t    state;
    arb_state_t    state_next;
    logic [CW-1:0] win_cnt;
    logic          window_open;
    logic          cpu_wr;

    assign window_open = (win_cnt != '0);
    assign cpu_wr      = cpu_write_strobe(cpu_ena_r, cpu_sel, cpu_we);

    // Host window counter: reloads on every phase-fall, then drains to zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_cnt <= '0;
        end else if (cpu_ena_f) begin
            win_cnt <= WIN_LOAD;
        end else if (window_open) begin
            win_cnt <= win_cnt - CW'(1);
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; an ack still showing blocks an immediate restart
    always_comb begin
        state_next = state;
        case (state)
            ARB_IDLE: begin
                if (host_req && window_open && !host_ack && !cpu_ena_r) begin
                    state_next = ARB_ADDR;
                end
            end
            ARB_ADDR: begin
                if (!cpu_ena_r) begin
                    state_next = ARB_DATA;
                end
            end
            ARB_DATA: begin
                state_next = ARB_IDLE;
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    // RAM port steering: CPU path by default, host path in ADDR/DATA unless a CPU write claims the clk
    always_comb begin
        mem_addr = cpu_addr;
        mem_din  = cpu_din;
        mem_we   = cpu_wr;
        busy     = (state != ARB_IDLE);
        case (state)
            ARB_ADDR: begin
                if (!cpu_wr) begin
                    mem_addr = host_addr;
                    mem_din  = host_din;
                    mem_we   = host_we & ~cpu_ena_r;
                end
            end
            ARB_DATA: begin
                if (!cpu_wr) begin
                    mem_addr = host_addr;
                    mem_we   = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    // Host completion: ack pulses the clk after DATA, read data captured from the RAM in DATA
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            host_ack  <= 1'b0;
            host_dout <= HOST_DOUT_RESET;
        end else begin
            host_ack <= (state == ARB_DATA);
            if (state == ARB_DATA && !host_we) begin
                host_dout <= mem_q;
            end
        end
    end

endmodule
